// File: rtl/pll_rstctl_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_rstctl_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_rstctl_state_t;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_CNT_W               = 17;
  localparam int unsigned RELOCK_W                = 8;

endpackage

// File: rtl/pll_reset_ctrl_bit_sync2.sv
// Two-flop synchronizer with synchronous active-low reset; also usable for button inputs.
module bit_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for stable lock, then releases sys_rst_n.
// Build option: define PLL_RSTCTL_TIMEOUT_EN to enable the WAIT_LOCK timeout/retry and the timeout flag.
module pll_reset_ctrl
  import pll_rstctl_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W               = DEF_CNT_W
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  sys_rst_n,
  output logic                  ready,
  output logic                  timeout,
  output logic [RELOCK_W-1:0]   relock_cnt,
  output pll_rstctl_state_t     dbg_state
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  logic                locked_s;
  pll_rstctl_state_t   state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic                pll_rst_q, pll_rst_d;
  logic                sys_rst_n_q, sys_rst_n_d;
  logic                ready_q, ready_d;
  logic                timeout_set;

  bit_sync2 u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_d     = state_q;
    relock_d    = relock_q;
    timeout_set = 1'b0;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
        end
`ifdef PLL_RSTCTL_TIMEOUT_EN
        else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          state_d     = PLL_RST;
          timeout_set = 1'b1;
        end
`endif
      end
      STABLE: begin
        // Lock loss is checked first so it beats the terminal count.
        if (!locked_s)                  state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)  state_d = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_d = PLL_RST;
          if (relock_q != {RELOCK_W{1'b1}}) relock_d = relock_q + RELOCK_W'(1);
        end
      end
      default: state_d = PLL_RST;
    endcase

    cnt_d       = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    // Outputs decode the next state so they are valid in the first cycle of it.
    pll_rst_d   = (state_d == PLL_RST);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      relock_q    <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      relock_q    <= relock_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
    end
  end

`ifdef PLL_RSTCTL_TIMEOUT_EN
  logic timeout_q, timeout_d;

  always_comb timeout_d = timeout_q | timeout_set;

  always_ff @(posedge refclk) begin
    if (!rst_n) timeout_q <= 1'b0;
    else        timeout_q <= timeout_d;
  end

  assign timeout = timeout_q;
`else
  assign timeout = timeout_set;
`endif

  assign pll_rst    = pll_rst_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign ready      = ready_q;
  assign relock_cnt = relock_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed self-checking bench for pll_reset_ctrl (small parameters, hand-computed edge timing).
module tb_pll_reset_ctrl;
  import pll_rstctl_pkg::*;

  logic              refclk = 1'b0;
  logic              rst_n;
  logic              pll_locked;
  logic              pll_rst;
  logic              sys_rst_n;
  logic              ready;
  logic              timeout;
  logic [7:0]        relock_cnt;
  pll_rstctl_state_t dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  pll_reset_ctrl #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (20),
    .CNT_W               (17)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .timeout    (timeout),
    .relock_cnt (relock_cnt),
    .dbg_state  (dbg_state)
  );

  always #10 refclk = ~refclk;

  // Advance n edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 8'(ready), 8'd1);
  endtask

  initial begin
    // Reset state
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    tick(3);
    check("rst_pll_rst",   8'(pll_rst),   8'd1);
    check("rst_sys_rst_n", 8'(sys_rst_n), 8'd0);
    check("rst_ready",     8'(ready),     8'd0);
    check("rst_timeout",   8'(timeout),   8'd0);
    check("rst_relock",    relock_cnt,    8'd0);
    check("rst_state",     8'(dbg_state), 8'(PLL_RST));

    // Bring-up with lock already high: release after 4+1+8 = 13 edges
    rst_n = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      check($sformatf("bu_pll_rst_%0d", i),   8'(pll_rst),   8'(i < 4));
      check($sformatf("bu_sys_rst_n_%0d", i), 8'(sys_rst_n), 8'(i >= 13));
      check($sformatf("bu_ready_%0d", i),     8'(ready),     8'(i >= 13));
    end
    check("bu_relock", relock_cnt, 8'd0);

    // Lock glitch in STABLE: drop after stable count 5 for 3 edges.
    // locked_s falls just as the count hits its terminal value; lock loss wins.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      check($sformatf("gl_sys_rst_n_%0d", i), 8'(sys_rst_n), 8'(i >= 24));
      if (i == 5)  check("gl_state_stable",  8'(dbg_state), 8'(STABLE));
      if (i == 13) check("gl_state_wait",    8'(dbg_state), 8'(WAIT_LOCK));
      if (i == 15) check("gl_state_wait2",   8'(dbg_state), 8'(WAIT_LOCK));
      if (i == 16) check("gl_state_restart", 8'(dbg_state), 8'(STABLE));
      if (i == 10) pll_locked = 1'b0;
      if (i == 13) pll_locked = 1'b1;
    end

    // Lock loss in RUN for one cycle: reset asserted 3 edges later, sequence repeats
    pll_locked = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) pll_locked = 1'b1;
      check($sformatf("rl_sys_rst_n_%0d", i), 8'(sys_rst_n), 8'((i < 3) || (i >= 16)));
      check($sformatf("rl_pll_rst_%0d", i),   8'(pll_rst),   8'((i >= 3) && (i <= 6)));
      check($sformatf("rl_relock_%0d", i),    relock_cnt,    (i >= 3) ? 8'd1 : 8'd0);
    end

    // Lock never arrives: retry every 4+20 edges only when the timeout is built in
    pll_locked = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
`ifdef PLL_RSTCTL_TIMEOUT_EN
      check($sformatf("to_pll_rst_%0d", i), 8'(pll_rst), 8'((i % 24) < 4));
      check($sformatf("to_timeout_%0d", i), 8'(timeout), 8'(i >= 24));
`else
      check($sformatf("to_pll_rst_%0d", i), 8'(pll_rst), 8'(i < 4));
      check($sformatf("to_timeout_%0d", i), 8'(timeout), 8'd0);
`endif
    end

    // Lock arrives; timeout flag must stay as it was
    pll_locked = 1'b1;
    wait_ready("to_recover_ready", 100);
`ifdef PLL_RSTCTL_TIMEOUT_EN
    check("to_sticky", 8'(timeout), 8'd1);
`else
    check("to_sticky", 8'(timeout), 8'd0);
`endif
    check("to_relock", relock_cnt, 8'd0);

    // Saturation: 260 lock losses in RUN
    for (int k = 1; k <= 260; k++) begin
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick(2);
      if (k == 1 || k == 200) check($sformatf("sat_drop_%0d", k), 8'(ready), 8'd0);
      wait_ready($sformatf("sat_ready_%0d", k), 40);
      if (k == 10)  check("sat_relock_10",  relock_cnt, 8'd10);
      if (k == 254) check("sat_relock_254", relock_cnt, 8'd254);
      if (k == 255) check("sat_relock_255", relock_cnt, 8'd255);
    end
    check("sat_relock_260", relock_cnt, 8'd255);

    // Reset mid-RUN for one edge
    rst_n = 1'b0;
    tick();
    check("mr_pll_rst",   8'(pll_rst),   8'd1);
    check("mr_sys_rst_n", 8'(sys_rst_n), 8'd0);
    check("mr_ready",     8'(ready),     8'd0);
    check("mr_timeout",   8'(timeout),   8'd0);
    check("mr_relock",    relock_cnt,    8'd0);
    check("mr_state",     8'(dbg_state), 8'(PLL_RST));
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Reset sequencer at the control end of the 50→25 MHz video PLL. Drives the PLL's active-high reset, watches its asynchronous `locked` output, and releases the system reset only after lock has been continuously stable for a programmable time. It runs on the free-running 50 MHz reference clock, so it keeps operating while the PLL output is absent or unstable. It sits between the board reset pin and every block in the 25 MHz VGA/game domain.

## Interface
- `PLL_RST_CYCLES`, default 16: refclk cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized-lock cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, default 65536: cycles allowed in WAIT_LOCK before a retry (≥2).
- `CNT_W`, default 17: shared counter width; must hold max(parameters)−1.
- `refclk` in 1: 50 MHz free-running clock, the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `pll_locked` in 1: PLL lock, asynchronous to `refclk`.
- `pll_rst` out 1: PLL reset, active high.
- `sys_rst_n` out 1: system reset, active low, refclk domain. Consumers in the 25 MHz domain resynchronize it.
- `ready` out 1: high exactly while in RUN.
- `timeout` out 1: sticky, set on the first lock timeout.
- `relock_cnt` out 8: count of lock losses seen in RUN, saturating at 255.

## Operation
- `pll_locked` passes through a 2-flop synchronizer (reset value 0) to give `locked_s`. All decisions use `locked_s` only.
- States are PLL_RST, WAIT_LOCK, STABLE and RUN, with one down-counter-free up counter `cnt`. `cnt` clears on every state change.
- PLL_RST: `pll_rst`=1.
  - When `cnt`==PLL_RST_CYCLES−1, go to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0.
  - If `locked_s`=1, go to STABLE.
  - Else if `cnt`==LOCK_TIMEOUT_CYCLES−1, set `timeout` and go to PLL_RST.
- STABLE: `pll_rst`=0.
  - If `locked_s`=0, go to WAIT_LOCK (the stability count restarts).
  - Else if `cnt`==LOCK_STABLE_CYCLES−1, go to RUN.
- RUN: `sys_rst_n`=1, `ready`=1.
  - If `locked_s`=0, go to PLL_RST and increment `relock_cnt` (saturating).
- Outputs are Moore and registered: each is decoded from the next state, so it is valid in the first cycle of the new state. There are no output glitches.
- `rst_n`=0 in any state, including mid-RUN, forces the reset state on the next edge.
  - Reset state: PLL_RST, `cnt`=0, synchronizer=0.
  - Reset outputs: `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `timeout`=0, `relock_cnt`=0.
- Lock loss and counter terminal value in the same cycle: lock loss wins.

## Timing
- From `pll_locked` rising to `locked_s` high: 2 cycles.
- With `locked_s` already high on WAIT_LOCK entry, WAIT_LOCK lasts 1 cycle.
- Nominal bring-up with lock already high: `sys_rst_n` rises PLL_RST_CYCLES+1+LOCK_STABLE_CYCLES cycles after the first edge with `rst_n`=1.
- Lock loss in RUN: `sys_rst_n` falls 3 edges after `pll_locked` falls (2 synchronizer + 1 state). `pll_rst` rises on the same edge.
- Timeout retry period: PLL_RST_CYCLES+LOCK_TIMEOUT_CYCLES cycles.

## Configuration
- `PLL_RSTCTL_TIMEOUT_EN`
  - Defined: WAIT_LOCK timeout, retry and the `timeout` flag behave as described above.
  - Undefined: WAIT_LOCK waits indefinitely, `timeout` is tied to 0, and the timeout compare logic is removed. The `LOCK_TIMEOUT_CYCLES` parameter stays but is ignored.

## Structure
- `pll_rstctl_pkg` holds:
  - the state enum `pll_rstctl_state_t` (PLL_RST, WAIT_LOCK, STABLE, RUN);
  - the default parameter constants;
  - `RELOCK_W`=8.
- Sub-module `bit_sync2`: a 2-flop synchronizer with synchronous active-low reset. It is reusable for the button inputs.

## Test plan
- Bring-up, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, `pll_locked`=1 from time 0, release `rst_n` -> `pll_rst` high for 4 cycles, `sys_rst_n`/`ready` rise exactly 13 cycles after release, `relock_cnt`=0.
- Lock glitch in STABLE: drop `pll_locked` for 3 cycles at stable count 5 -> return to WAIT_LOCK, full 8-cycle stability window restarts, `sys_rst_n` stays 0 throughout.
- Lock loss in RUN: drop `pll_locked` for 1 cycle -> `sys_rst_n`=0 and `pll_rst`=1 three edges later, `relock_cnt`=1, full sequence repeats.
- Timeout (macro defined), LOCK_TIMEOUT_CYCLES=20, `pll_locked`=0 -> `pll_rst` re-pulses every 24 cycles, `timeout`=1 from the first expiry and stays set. Macro undefined -> no re-pulse, `timeout`=0.
- Saturation: 260 lock losses in RUN -> `relock_cnt`=255.
- Reset mid-RUN: `rst_n`=0 for 1 cycle -> next edge `pll_rst`=1, `sys_rst_n`=0, `timeout`=0, `relock_cnt`=0.
